score_display_driver: RTL and testbench

- Downstream consumer of the scorekeeper's score / highScore registers.
- Periodically samples the selected value and converts it from binary to BCD using a multi-cycle double-dabble engine.
- Drives DIGITS seven-segment displays (active-low, DE1-SoC HEX style) plus a raw BCD bus for the VGA score overlay.
- Refresh is throttled so the display is stable and the conversion does not need to be single-cycle.

---
 rtl/score_display_pkg.sv | 24 ++
 rtl/bcd_to_7seg.sv | 22 ++
 rtl/score_display_driver.sv | 172 +++++++++++++++++
 tb/tb_score_display_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types, segment table and sizing helper for the score display driver.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [0:9][6:0] SEG_TABLE = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // BCD nibbles needed to hold any WIDTH-bit binary value.
  function automatic int calc_nb(input int width);
    return (width * 32'sd3) / 32'sd10 + 32'sd1;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD nibble to active-low seven-segment pattern, with a forced-blank input.
module bcd_to_7seg
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 or an explicit blank turns all segments off.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// Throttled binary-to-BCD display driver with multi-cycle double-dabble conversion.
// Leading-zero blanking of the segment outputs is enabled by SCORE_DISPLAY_LZB_EN.
module score_display_driver
  import score_display_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int REFRESH_HZ      = 20,
  parameter int WIDTH           = 32,
  parameter int DIGITS          = 6
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      score,
  input  logic [WIDTH-1:0]      highScore,
  input  logic                  showHigh,
  input  logic                  freeze,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int NB = calc_nb(WIDTH);
  localparam int TW = $clog2(CLOCK_FREQUENCY) + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(CLOCK_FREQUENCY / REFRESH_HZ - 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                show_high_q, pending_q, pending_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*NB-1:0]     acc_q, acc_d, acc_adj_s;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, sat_bcd_s;
  logic [7*DIGITS-1:0] hex_q, hex_d, seg_s;
  logic                overflow_q, overflow_d, busy_q, busy_d, done_q, done_d;
  logic                tick_s, start_s, ovf_s;
  logic [3:0]          nib_s;
  logic [DIGITS-1:0]   blank_s;
`ifdef SCORE_DISPLAY_LZB_EN
  logic                lead_s;
`endif

  // Result view of the accumulator: saturate to all nines when the value does not fit.
  always_comb begin
    ovf_s     = |acc_q[4*NB-1:4*DIGITS];
    sat_bcd_s = ovf_s ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
  end

  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    blank_s = '0;
`ifdef SCORE_DISPLAY_LZB_EN
    lead_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead_s     = lead_s & (sat_bcd_s[4*i +: 4] == 4'd0);
      blank_s[i] = lead_s;
    end
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_7seg u_seg (
      .digit (sat_bcd_s[4*g +: 4]),
      .blank (blank_s[g]),
      .seg   (seg_s[7*g +: 7])
    );
  end

  // Next-state logic: refresh tick, pending request and the conversion sequence.
  always_comb begin
    tick_s     = (tick_cnt_q == '0);
    tick_cnt_d = tick_s ? TICK_RELOAD : tick_cnt_q - TW'(1);
    start_s    = (state_q == ST_IDLE) && (tick_s || pending_q) && !freeze;
    pending_d  = start_s ? 1'b0 : (pending_q | tick_s | (showHigh ^ show_high_q));

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    acc_adj_s = acc_q;
    nib_s     = 4'd0;
    for (int i = 0; i < NB; i++) begin
      nib_s                = acc_q[4*i +: 4];
      acc_adj_s[4*i +: 4]  = (nib_s >= 4'd5) ? nib_s + 4'd3 : nib_s;
    end

    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bin_d     = showHigh ? highScore : score;
        acc_d     = '0;
        bit_cnt_d = CW'(WIDTH);
        busy_d    = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d     = {acc_adj_s[4*NB-2:0], bin_q[WIDTH-1]};
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CW'(1);
        if (bit_cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d      = sat_bcd_s;
        hex_d      = seg_s;
        overflow_d = ovf_s;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the display and aborts any conversion.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= TICK_RELOAD;
      show_high_q <= 1'b0;
      pending_q   <= 1'b0;
      bin_q       <= '0;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      bcd_q       <= '0;
      hex_q       <= '1;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      show_high_q <= showHigh;
      pending_q   <= pending_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      bcd_q       <= bcd_d;
      hex_q       <= hex_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign hex_out  = hex_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver: cycle-level model plus directed scenarios.
module tb_score_display_driver;

  localparam int CF  = 1000;
  localparam int RH  = 10;
  localparam int W   = 32;
  localparam int DIG = 6;
  localparam int P   = CF / RH;
  localparam int LAT = W + 2;

`ifdef SCORE_DISPLAY_LZB_EN
  localparam logic [41:0] HEX_ZERO = {{5{7'h7F}}, 7'h40};
  localparam logic [41:0] HEX_1234 = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
`else
  localparam logic [41:0] HEX_ZERO = {6{7'h40}};
  localparam logic [41:0] HEX_1234 = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
`endif
  localparam logic [41:0] HEX_NINES = {6{7'h10}};

  logic              Clock = 1'b0;
  logic              reset = 1'b1;
  logic [W-1:0]      score = '0, highScore = '0;
  logic              showHigh = 1'b0, freeze = 1'b0;
  logic [4*DIG-1:0]  bcd_out;
  logic [7*DIG-1:0]  hex_out;
  logic              overflow, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  score_display_driver #(.CLOCK_FREQUENCY(CF), .REFRESH_HZ(RH), .WIDTH(W), .DIGITS(DIG)) dut (
    .Clock(Clock), .reset(reset), .score(score), .highScore(highScore),
    .showHigh(showHigh), .freeze(freeze), .bcd_out(bcd_out), .hex_out(hex_out),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int                m_k, m_start, m_end;
  bit                m_pend, m_prev_sh, m_fly;
  longint unsigned   m_val;
  logic [4*DIG-1:0]  m_bcd;
  logic [7*DIG-1:0]  m_hex;
  logic              m_ovf, m_busy, m_done;

  task automatic model_reset();
    m_k = 0; m_pend = 0; m_prev_sh = 0; m_fly = 0; m_start = 0; m_end = 0; m_val = 0;
    m_bcd = '0; m_hex = '1; m_ovf = 0; m_busy = 0; m_done = 0;
  endtask

  // Decimal rendering of a value straight from arithmetic.
  task automatic publish(input longint unsigned v);
    longint unsigned p10, lim;
    int d;
    lim = 1;
    for (int i = 0; i < DIG; i++) lim = lim * 10;
    m_ovf = (v > lim - 1);
    p10 = 1;
    for (int i = 0; i < DIG; i++) begin
      d = m_ovf ? 9 : int'((v / p10) % 10);
      m_bcd[4*i +: 4] = 4'(d);
      m_hex[7*i +: 7] = seg_tbl[d];
`ifdef SCORE_DISPLAY_LZB_EN
      if (!m_ovf && i > 0 && v < p10) m_hex[7*i +: 7] = 7'h7F;
`endif
      p10 = p10 * 10;
    end
  endtask

  // One clock edge: ticks every P edges, a conversion samples on start+1 and publishes on start+LAT.
  task automatic model_step(input logic [W-1:0] sc, input logic [W-1:0] hs, input bit sh, input bit frz);
    bit tick, shc;
    tick = ((m_k % P) == P - 1);
    shc  = (sh != m_prev_sh);
    m_prev_sh = sh;
    m_done = 0;
    if (m_fly && m_k == m_start + 1) m_val = sh ? longint'(hs) : longint'(sc);
    if (m_fly && m_k == m_end) begin
      publish(m_val);
      m_done = 1; m_fly = 0; m_busy = 0;
      m_pend = m_pend | tick | shc;
    end else if (!m_fly && (tick || m_pend) && !frz) begin
      m_fly = 1; m_start = m_k; m_end = m_k + LAT; m_pend = 0;
    end else begin
      m_pend = m_pend | tick | shc;
      if (m_fly && m_k >= m_start + 1) m_busy = 1;
    end
    m_k++;
  endtask

  // Compare process: step the model on each rising edge, check every output on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge Clock);
      if (reset) model_reset();
      else model_step(score, highScore, showHigh, freeze);
      @(negedge Clock);
      if (reset) model_reset();
      chk("bcd_out",  64'(bcd_out),  64'(m_bcd));
      chk("hex_out",  64'(hex_out),  64'(m_hex));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("busy",     64'(busy),     64'(m_busy));
      chk("done",     64'(done),     64'(m_done));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic wait_done(input string nm, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge Clock); #2; n++;
    end while (n < maxc && done !== 1'b1);
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic wait_busy(input string nm, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge Clock); #2; n++;
    end while (n < maxc && busy !== 1'b1);
    chk({nm, "_busy_seen"}, 64'(busy), 64'd1);
  endtask

  initial begin
    int n, ndone;
    cyc(3);
    chk("reset_hex", 64'(hex_out), 64'({42{1'b1}}));
    chk("reset_bcd", 64'(bcd_out), 64'd0);
    reset = 1'b0;

    // First tick after reset converts score 0.
    wait_done("zero", 200, n);
    chk("zero_latency", 64'(n), 64'(P + LAT));
    chk("zero_bcd", 64'(bcd_out), 64'h0);
    chk("zero_hex", 64'(hex_out), 64'(HEX_ZERO));
    chk("model_zero_hex", 64'(m_hex), 64'(HEX_ZERO));

    score = 32'd1234;
    wait_done("s1234", 150, n);
    chk("s1234_bcd", 64'(bcd_out), 64'h001234);
    chk("s1234_hex", 64'(hex_out), 64'(HEX_1234));
    chk("model_1234_bcd", 64'(m_bcd), 64'h001234);

    score = 32'd999999;
    wait_done("s999999", 150, n);
    chk("s999999_bcd", 64'(bcd_out), 64'h999999);
    chk("s999999_ovf", 64'(overflow), 64'd0);

    score = 32'd1000000;
    wait_done("s1e6", 150, n);
    chk("s1e6_ovf", 64'(overflow), 64'd1);
    chk("s1e6_bcd", 64'(bcd_out), 64'h999999);
    chk("s1e6_hex", 64'(hex_out), 64'(HEX_NINES));

    // showHigh flips mid-conversion: current result intact, follow-up without a tick.
    score = 32'd5; highScore = 32'd777;
    wait_busy("sh", 150, n);
    cyc(10);
    showHigh = 1'b1;
    wait_done("sh_first", 60, n);
    chk("sh_first_bcd", 64'(bcd_out), 64'h000005);
    wait_done("sh_second", 60, n);
    chk("sh_second_fast", 64'(n < 40), 64'd1);
    chk("sh_second_bcd", 64'(bcd_out), 64'h000777);
    showHigh = 1'b0;
    wait_done("sh_back", 60, n);
    chk("sh_back_bcd", 64'(bcd_out), 64'h000005);

    // Freeze across three ticks: no updates while score moves.
    freeze = 1'b1;
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 40)  score = 32'd111;
      if (i == 140) score = 32'd222;
      if (i == 240) score = 32'd4242;
      cyc(1);
      if (done === 1'b1) ndone++;
    end
    chk("freeze_no_done", 64'(ndone), 64'd0);
    chk("freeze_hold_bcd", 64'(bcd_out), 64'h000005);
    freeze = 1'b0;
    wait_busy("unfreeze", 5, n);
    chk("unfreeze_prompt", 64'(n), 64'd2);
    wait_done("unfreeze", 60, n);
    chk("unfreeze_bcd", 64'(bcd_out), 64'h004242);

    // Reset in the middle of a conversion.
    score = 32'd31415;
    wait_busy("rst", 150, n);
    cyc(5);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_hex", 64'(hex_out), 64'({42{1'b1}}));
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_bcd", 64'(bcd_out), 64'd0);
    cyc(2);
    reset = 1'b0;
    wait_done("after_rst", 200, n);
    chk("after_rst_latency", 64'(n), 64'(P + LAT));
    chk("after_rst_bcd", 64'(bcd_out), 64'h031415);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
